// File: rtl/counter_pkg.sv
// Shared types and constants for the counter decoder: tracker states and step classes.
package counter_pkg;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PRIMED = 2'd1,
    S_TRACK  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    STEP_HOLD  = 3'd0,
    STEP_UP    = 3'd1,
    STEP_DOWN  = 3'd2,
    STEP_RESET = 3'd3,
    STEP_ERR   = 3'd4
  } step_t;

  // The DOWN delta is all-ones at whatever WIDTH the classifier is built with.
  localparam int DELTA_UP = 1;

endpackage

// File: rtl/counter_step_classifier.sv
// Combinational classifier: labels the step from prev to count_in, modulo 2**WIDTH.
module counter_step_classifier
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_t            step
);

  localparam logic [WIDTH-1:0] D_UP   = WIDTH'(DELTA_UP);
  localparam logic [WIDTH-1:0] D_DOWN = '1;

  logic [WIDTH-1:0] delta;

  assign delta = count_in - prev;

  // Order matters: wraps 255->0 and 1->0 must win over the reset rule.
  always_comb begin
    step = STEP_ERR;
    if (delta == '0)
      step = STEP_HOLD;
    else if (delta == D_UP)
      step = STEP_UP;
    else if (delta == D_DOWN)
      step = STEP_DOWN;
    else if (count_in == '0)
      step = STEP_RESET;
  end

endmodule

// File: rtl/counter_decoder.sv
// Receive-side monitor for an up/down counter: recovers enable/direction, flags resets and jumps.
// Build option COUNTER_DECODER_LOCK_EN: direction_out flips only after LOCK_N agreeing moves.
//
// state    | meaning
// S_EMPTY  | no sample held yet; next sample only primes prev
// S_PRIMED | one sample held; next sample produces the first classified step
// S_TRACK  | classifying every sample against the previous one
module counter_decoder
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
`ifdef COUNTER_DECODER_LOCK_EN
  ,
  parameter int LOCK_N = 2
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_in,
  output logic             valid_out,
  output logic             enable_out,
  output logic             direction_out,
  output logic             rst_seen,
  output logic             err,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] err_count
);

  state_t           state;
  logic [WIDTH-1:0] prev;
  step_t            step;
  step_t            last_step;
  logic             moving;
  logic             step_dir;

  counter_step_classifier #(.WIDTH(WIDTH)) u_classifier (
    .prev     (prev),
    .count_in (count_in),
    .step     (step)
  );

  assign moving   = (step == STEP_UP) || (step == STEP_DOWN);
  assign step_dir = (step == STEP_UP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      prev       <= '0;
      last_step  <= STEP_HOLD;
      valid_out  <= 1'b0;
      enable_out <= 1'b0;
      rst_seen   <= 1'b0;
      err        <= 1'b0;
      run_len    <= '0;
      err_count  <= '0;
    end else begin
      prev <= count_in;
      if (state == S_EMPTY) begin
        state <= S_PRIMED;
      end else begin
        state      <= S_TRACK;
        valid_out  <= 1'b1;
        last_step  <= step;
        enable_out <= moving;
        rst_seen   <= (step == STEP_RESET);
        err        <= (step == STEP_ERR);
        if (step == STEP_ERR && err_count != '1)
          err_count <= err_count + CNT_W'(1);
        // The first classified step has no predecessor, so it always starts a new run.
        if (state == S_PRIMED || step != last_step)
          run_len <= CNT_W'(1);
        else if (run_len != '1)
          run_len <= run_len + CNT_W'(1);
      end
    end
  end

`ifdef COUNTER_DECODER_LOCK_EN
  localparam int LOCK_W = $clog2(LOCK_N + 1);

  logic [LOCK_W-1:0] lock_cnt;

  // lock_cnt counts consecutive moves opposing the current direction_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      direction_out <= 1'b0;
      lock_cnt      <= '0;
    end else if (state != S_EMPTY) begin
      if (!moving || step_dir == direction_out) begin
        lock_cnt <= '0;
      end else if (int'(lock_cnt) + 1 >= LOCK_N) begin
        direction_out <= step_dir;
        lock_cnt      <= '0;
      end else begin
        lock_cnt <= lock_cnt + LOCK_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n)
      direction_out <= 1'b0;
    else if (state != S_EMPTY && moving)
      direction_out <= step_dir;
  end
`endif

endmodule

// File: tb/tb_counter_decoder.sv
// Scoreboard bench for counter_decoder: directed vectors push expected outputs, a monitor checks them.
module tb_counter_decoder;

`ifdef COUNTER_DECODER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] count_in;
  logic       valid_out, enable_out, direction_out, rst_seen, err;
  logic [7:0] run_len, err_count;

  typedef struct packed {
    logic       v;
    logic       e;
    logic       d;
    logic       r;
    logic       er;
    logic [7:0] rl;
    logic [7:0] ec;
  } obs_t;

  typedef struct packed {
    logic [15:0] id;
    obs_t        obs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 1'b0;

  counter_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .count_in      (count_in),
    .valid_out     (valid_out),
    .enable_out    (enable_out),
    .direction_out (direction_out),
    .rst_seen      (rst_seen),
    .err           (err),
    .run_len       (run_len),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one registered result per sampled vector, checked 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      obs_t a;
      x = exp_q.pop_front();
      a = '{valid_out, enable_out, direction_out, rst_seen, err, run_len, err_count};
      n_checks++;
      if (a !== x.obs) begin
        n_errors++;
        $display("FAIL vec%0d: got v=%b e=%b d=%b rst=%b err=%b run=%0d errc=%0d, want v=%b e=%b d=%b rst=%b err=%b run=%0d errc=%0d",
                 x.id, a.v, a.e, a.d, a.r, a.er, a.rl, a.ec,
                 x.obs.v, x.obs.e, x.obs.d, x.obs.r, x.obs.er, x.obs.rl, x.obs.ec);
      end
    end
  end

  int vid = 0;

  task automatic drive(input logic rst, input logic [7:0] cnt,
                       input logic v, input logic e, input logic d,
                       input logic r, input logic er,
                       input logic [7:0] rl, input logic [7:0] ec);
    exp_t x;
    @(negedge clk);
    rst_n    = rst;
    count_in = cnt;
    x.id     = 16'(vid);
    x.obs    = '{v, e, d, r, er, rl, ec};
    exp_q.push_back(x);
    vid++;
  endtask

  initial begin
    rst_n    = 1'b0;
    count_in = 8'd0;

    //     rst cnt   v  e  d              r  er run ec
    // reset
    drive(0, 8'd0,   0, 0, 0,             0, 0, 0, 0);
    drive(0, 8'd0,   0, 0, 0,             0, 0, 0, 0);
    // held value: first sample only primes, then HOLD runs 1,2,3
    drive(1, 8'd5,   0, 0, 0,             0, 0, 0, 0);
    drive(1, 8'd5,   1, 0, 0,             0, 0, 1, 0);
    drive(1, 8'd5,   1, 0, 0,             0, 0, 2, 0);
    drive(1, 8'd5,   1, 0, 0,             0, 0, 3, 0);
    // jump to 253 is illegal, then counting up through the 255->0 wrap
    drive(1, 8'd253, 1, 0, 0,             0, 1, 1, 1);
    drive(1, 8'd254, 1, 1, LOCK ? 0 : 1,  0, 0, 1, 1);
    drive(1, 8'd255, 1, 1, 1,             0, 0, 2, 1);
    drive(1, 8'd0,   1, 1, 1,             0, 0, 3, 1);
    drive(1, 8'd1,   1, 1, 1,             0, 0, 4, 1);
    // counting down through 1->0 and the 0->255 wrap
    drive(1, 8'd2,   1, 1, 1,             0, 0, 5, 1);
    drive(1, 8'd1,   1, 1, LOCK ? 1 : 0,  0, 0, 1, 1);
    drive(1, 8'd0,   1, 1, 0,             0, 0, 2, 1);
    drive(1, 8'd255, 1, 1, 0,             0, 0, 3, 1);
    // 255->40 illegal; climb, then a jump to 0 is a counter reset
    drive(1, 8'd40,  1, 0, 0,             0, 1, 1, 2);
    drive(1, 8'd41,  1, 1, LOCK ? 0 : 1,  0, 0, 1, 2);
    drive(1, 8'd42,  1, 1, 1,             0, 0, 2, 2);
    drive(1, 8'd0,   1, 0, 1,             1, 0, 1, 2);
    // two illegal jumps in a row, then reset mid-run
    drive(1, 8'd10,  1, 0, 1,             0, 1, 1, 3);
    drive(1, 8'd17,  1, 0, 1,             0, 1, 2, 4);
    drive(0, 8'd17,  0, 0, 0,             0, 0, 0, 0);
    drive(0, 8'd0,   0, 0, 0,             0, 0, 0, 0);
    // direction lock pattern
    drive(1, 8'd7,   0, 0, 0,             0, 0, 0, 0);
    drive(1, 8'd8,   1, 1, LOCK ? 0 : 1,  0, 0, 1, 0);
    drive(1, 8'd9,   1, 1, 1,             0, 0, 2, 0);
    drive(1, 8'd10,  1, 1, 1,             0, 0, 3, 0);
    drive(1, 8'd9,   1, 1, LOCK ? 1 : 0,  0, 0, 1, 0);
    drive(1, 8'd10,  1, 1, 1,             0, 0, 1, 0);
    drive(1, 8'd9,   1, 1, LOCK ? 1 : 0,  0, 0, 1, 0);
    drive(1, 8'd8,   1, 1, 0,             0, 0, 2, 0);
    // long hold: run_len saturates at 255
    for (int i = 1; i <= 260; i++)
      drive(1, 8'd8, 1, 0, 0, 0, 0, (i > 255) ? 8'd255 : 8'(i), 0);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000, want finish");
    $fatal(1);
  end

endmodule
